// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receive path: decoder state encoding,
// pulse-width windows in microseconds and the button codes the mode FSM uses.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW
  } ir_state_e;

  // clk_50 cycles per microsecond tick
  localparam int US_DIV = 50;

  // Width counters
  localparam int CNT_W  = 14;
  localparam int HOLD_W = 17;

  // Phase-width windows, microseconds, inclusive
  localparam int LEAD_LOW_MIN  = 8000;
  localparam int LEAD_LOW_MAX  = 10000;
  localparam int LEAD_HIGH_MIN = 4000;
  localparam int LEAD_HIGH_MAX = 5000;
  localparam int RPT_HIGH_MIN  = 2000;
  localparam int RPT_HIGH_MAX  = 2500;
  localparam int BIT_MIN       = 400;
  localparam int BIT_MAX       = 700;
  localparam int ONE_MIN       = 1400;
  localparam int ONE_MAX       = 1900;

  // Abort threshold for any phase while a frame is in progress
  localparam int TIMEOUT_US = 10000;
  // Time without a fresh code or repeat before the held button is dropped
  localparam int HOLD_US    = 120000;

  // Button codes shared with the mode FSM
  localparam logic [7:0] BTN_CAM  = 8'h0F;
  localparam logic [7:0] BTN_IR   = 8'h13;
  localparam logic [7:0] BTN_IDLE = 8'h10;

  // True when a measured width lies inside [lo, hi]
  function automatic logic in_win(input logic [CNT_W-1:0] w, input int lo, input int hi);
    return (int'(w) >= lo) && (int'(w) <= hi);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Microsecond prescaler: one-cycle us_tick every DIV clk_50 cycles.
module ir_tick_gen
  import ir_pkg::*;
#(
  parameter int DIV = US_DIV
) (
  input  logic clk_50,
  input  logic reset_n,
  output logic us_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Free-running divider; the tick is registered so it is glitch-free
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      div_cnt <= '0;
      us_tick <= 1'b0;
    end else begin
      us_tick <= (div_cnt == LAST);
      if (div_cnt == LAST) div_cnt <= '0;
      else                 div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder. Measures each low/high phase of the synchronized
// receiver signal in microseconds and walks the leader / 32 data bits / stop
// sequence. Result pulses (code_valid, repeat_pulse, frame_error) are
// single-cycle and mutually exclusive; IR_button holds the last good command
// until a 120 ms quiet period clears it.
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int TICK_DIV = US_DIV
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       ir_rx,
  output logic [7:0] IR_button,
  output logic       code_valid,
  output logic       repeat_pulse,
  output logic       frame_error
);

  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT_US);
  localparam logic [HOLD_W-1:0] HOLD_END    = HOLD_W'(HOLD_US);

  logic              us_tick;
  logic              rx_s1, rx_s2, rx_s3;
  logic              rise, fall, edge_det;
  logic [CNT_W-1:0]  width_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  ir_state_e         state;
  logic [4:0]        bit_cnt;
  logic [31:0]       shift;
  logic              rpt;
  logic              zero_ok, one_ok;

  ir_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .us_tick (us_tick)
  );

  // Two-flop synchronizer plus a delay flop for edge detection; idle level is 1
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= ir_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rise     = rx_s2 & ~rx_s3;
  assign fall     = ~rx_s2 & rx_s3;
  assign edge_det = rise | fall;
  assign zero_ok  = in_win(width_cnt, BIT_MIN, BIT_MAX);
  assign one_ok   = in_win(width_cnt, ONE_MIN, ONE_MAX);

  // Phase width in microseconds; restarts on every edge, saturates at all-ones
  always_ff @(posedge clk_50) begin
    if (!reset_n)                     width_cnt <= '0;
    else if (edge_det)                width_cnt <= '0;
    else if (us_tick && width_cnt != '1) width_cnt <= width_cnt + CNT_W'(1);
  end

  // Button hold timer; restarted by every accepted code or repeat
  always_ff @(posedge clk_50) begin
    if (!reset_n)                          hold_cnt <= '0;
    else if (code_valid || repeat_pulse)   hold_cnt <= '0;
    else if (us_tick && hold_cnt != HOLD_END) hold_cnt <= hold_cnt + HOLD_W'(1);
  end

  assign hold_done = (hold_cnt == HOLD_END);

  // Frame FSM with registered result pulses and held button
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      rpt          <= 1'b0;
      IR_button    <= 8'h00;
      code_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      code_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_error  <= 1'b0;
      // The cycle after a fresh code the timer still reads its old value
      if (hold_done && !code_valid) IR_button <= 8'h00;

      if (state != IDLE && !edge_det && width_cnt >= TIMEOUT_CNT) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        shift       <= '0;
        frame_error <= 1'b1;
      end else if (edge_det) begin
        case (state)
          IDLE: begin
            if (fall) begin
              state <= LEAD_LOW;
              rpt   <= 1'b0;
            end
          end
          LEAD_LOW: begin
            if (rise && in_win(width_cnt, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
              state <= LEAD_HIGH;
            end else begin
              state       <= IDLE;
              frame_error <= 1'b1;
            end
          end
          LEAD_HIGH: begin
            if (fall && in_win(width_cnt, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
              state   <= BIT_LOW;
              bit_cnt <= '0;
              shift   <= '0;
            end else if (fall && in_win(width_cnt, RPT_HIGH_MIN, RPT_HIGH_MAX)) begin
              state <= STOP_LOW;
              rpt   <= 1'b1;
            end else begin
              state       <= IDLE;
              frame_error <= 1'b1;
            end
          end
          BIT_LOW: begin
            if (rise && zero_ok) begin
              state <= BIT_HIGH;
            end else begin
              state       <= IDLE;
              bit_cnt     <= '0;
              shift       <= '0;
              frame_error <= 1'b1;
            end
          end
          BIT_HIGH: begin
            if (fall && (zero_ok || one_ok)) begin
              // LSB first: new bit enters at the top and ripples down
              shift <= {one_ok, shift[31:1]};
              if (bit_cnt == 5'd31) begin
                state <= STOP_LOW;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                state   <= BIT_LOW;
              end
            end else begin
              state       <= IDLE;
              bit_cnt     <= '0;
              shift       <= '0;
              frame_error <= 1'b1;
            end
          end
          STOP_LOW: begin
            state <= IDLE;
            if (rise && zero_ok) begin
              if (rpt) begin
                repeat_pulse <= (IR_button != 8'h00) && !hold_done;
              end else if (shift[23:16] == ~shift[31:24]) begin
                IR_button  <= shift[23:16];
                code_valid <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
            end
            bit_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Bench for ir_nec_decoder. The prescaler runs at one tick per clock so a
// microsecond of IR timing costs one clk_50 cycle. Each frame-ending edge
// pushes {cycle, {code_valid, repeat_pulse, frame_error}, IR_button} into
// exp_q; a monitor pops and compares on every result pulse.
module tb_ir_nec_decoder;
  import ir_pkg::*;

  localparam int W = 43;

  logic       clk_50;
  logic       reset_n;
  logic       ir_rx;
  logic [7:0] IR_button;
  logic       code_valid;
  logic       repeat_pulse;
  logic       frame_error;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] exp_btn = 8'h00;
  logic [W-1:0] exp_q[$];

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_RPT   = 3'b010;
  localparam logic [2:0] K_ERR   = 3'b001;

  ir_nec_decoder #(.TICK_DIV(1)) dut (
    .clk_50       (clk_50),
    .reset_n      (reset_n),
    .ir_rx        (ir_rx),
    .IR_button    (IR_button),
    .code_valid   (code_valid),
    .repeat_pulse (repeat_pulse),
    .frame_error  (frame_error)
  );

  // clock / reset
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks; ir_rx only changes at negedges
  task automatic ir_mark(input int us);
    ir_rx = 1'b0;
    repeat (us) @(negedge clk_50);
  endtask

  task automatic ir_space(input int us);
    ir_rx = 1'b1;
    repeat (us) @(negedge clk_50);
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [7:0] btn);
    exp_q.push_back({32'(cyc + 3), kind, btn});
  endtask

  // abort_bit: stretch that bit's high phase to 1000 us; reset_bit: reset
  // inside that bit's high phase and stop transmitting
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cmd,
                            input logic [7:0] inv, input int abort_bit,
                            input int reset_bit);
    logic [31:0] d;
    d = {inv, cmd, ~addr, addr};
    ir_mark(8500);
    ir_space(4200);
    for (int i = 0; i < 32; i++) begin
      ir_mark(450);
      if (i == reset_bit) begin
        ir_space(200);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_50);
        chk("reset_button", 48'(IR_button), 48'h0);
        chk("reset_pulses", 48'({code_valid, repeat_pulse, frame_error}), 48'h0);
        reset_n = 1'b1;
        exp_btn = 8'h00;
        return;
      end
      if (i == abort_bit) begin
        ir_space(1000);
        ir_rx = 1'b0;
        push_exp(K_ERR, exp_btn);
        ir_mark(450);
        ir_rx = 1'b1;
        return;
      end
      ir_space(d[i] ? 1450 : 450);
    end
    ir_mark(450);
    ir_rx = 1'b1;
    if (cmd == ~inv) begin
      exp_btn = cmd;
      push_exp(K_VALID, cmd);
    end else begin
      push_exp(K_ERR, exp_btn);
    end
  endtask

  task automatic send_repeat();
    ir_mark(8500);
    ir_space(2100);
    ir_mark(450);
    ir_rx = 1'b1;
    if (exp_btn != 8'h00) push_exp(K_RPT, exp_btn);
  endtask

  // scoreboard monitor: every result pulse must match the head of exp_q
  initial begin
    logic [W-1:0] obs;
    forever begin
      @(posedge clk_50);
      cyc++;
      #1;
      if (code_valid || repeat_pulse || frame_error) begin
        obs = {32'(cyc), code_valid, repeat_pulse, frame_error, IR_button};
        if (exp_q.size() == 0) chk("unexpected_pulse", 48'(obs), 48'h0);
        else                   chk("pulse_event", 48'(obs), 48'(exp_q.pop_front()));
      end
    end
  end

  // main sequence
  initial begin
    reset_n = 1'b0;
    ir_rx   = 1'b1;
    repeat (5) @(negedge clk_50);
    chk("init_button", 48'(IR_button), 48'h0);
    chk("init_pulses", 48'({code_valid, repeat_pulse, frame_error}), 48'h0);
    reset_n = 1'b1;
    ir_space(1000);

    // good frame, cmd 0x0F
    send_frame(8'h00, BTN_CAM, ~BTN_CAM, -1, -1);
    ir_space(40000);
    chk("t1_button", 48'(IR_button), 48'(BTN_CAM));

    // repeat frame 40 ms later
    send_repeat();
    ir_space(5000);
    chk("t2_button", 48'(IR_button), 48'(BTN_CAM));

    // bad inverse command
    send_frame(8'h00, BTN_IR, 8'hEE, -1, -1);
    ir_space(5000);
    chk("t3_button", 48'(IR_button), 48'(BTN_CAM));

    // 1000 us high at bit 5, then a good 0x10 frame
    send_frame(8'h00, BTN_IR, ~BTN_IR, 5, -1);
    ir_space(5000);
    chk("t4_abort_button", 48'(IR_button), 48'(BTN_CAM));
    send_frame(8'h00, BTN_IDLE, ~BTN_IDLE, -1, -1);
    ir_space(5000);
    chk("t4_button", 48'(IR_button), 48'(BTN_IDLE));

    // reset during bit 12, then a full frame
    send_frame(8'h00, BTN_CAM, ~BTN_CAM, -1, 12);
    ir_space(5000);
    chk("t6_idle_button", 48'(IR_button), 48'h0);
    send_frame(8'h00, BTN_IR, ~BTN_IR, -1, -1);

    // 120 ms silence drops the button; a later repeat is ignored
    ir_space(119000);
    chk("t5_hold_before", 48'(IR_button), 48'(BTN_IR));
    ir_space(2000);
    chk("t5_hold_after", 48'(IR_button), 48'h0);
    exp_btn = 8'h00;
    send_repeat();
    ir_space(2000);
    chk("t5_button", 48'(IR_button), 48'h0);

    chk("exp_q_empty", 48'(exp_q.size()), 48'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
